// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC owner: accepts redirects over valid/ready, drives IMEM address, PC+4 and IF/ID flush.
// Latency: redirect fire (no stall) -> pc_out == target on the next cycle, with a coincident flush pulse.
// Backpressure: redirect_ready drops while a redirect is parked behind a hazard stall (HELD state).
//
// Ports: clock/reset (sync, active-high); stall_in freezes the PC; redirect_valid/_ready/_target
// handshake from ID; pc_out, pc_plus_4_out, fetch_valid, flush_if_id, misalign_err are registered.
// Optional feature: define MISALIGN_TRAP_EN to send misaligned redirects to TRAP_VECTOR and raise a
// sticky misalign_err; otherwise target[1:0] is cleared and misalign_err is tied low.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        redirect_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic        fetch_valid,
  output logic        flush_if_id,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HELD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] pend_q;
  logic        fv_q;
  logic        flush_q;

  logic        fire;
  logic        load_now;
  logic        park_now;
  logic [31:0] src_d;
  logic [31:0] load_addr_d;
  logic        load_err_d;

  assign redirect_ready = !reset && (state_q != ST_HELD);
  assign fire           = redirect_valid && redirect_ready;

  // A redirect reaches the PC either straight from ID (no stall) or from the
  // parked copy once the stall releases.
  assign load_now = !stall_in && ((state_q == ST_HELD) || fire);
  assign park_now = stall_in && fire;
  assign src_d    = (state_q == ST_HELD) ? pend_q : redirect_target;

`ifdef MISALIGN_TRAP_EN
  assign load_err_d  = |src_d[1:0];
  assign load_addr_d = load_err_d ? TRAP_VECTOR : src_d;
`else
  assign load_err_d  = 1'b0;
  assign load_addr_d = src_d & ~32'h0000_0003;
`endif

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (load_now && load_err_d) begin
      err_q <= 1'b1;
    end
  end
  assign misalign_err = err_q;
`else
  logic unused_err;
  assign unused_err   = load_err_d;
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + 32'd4;
      pend_q  <= 32'h0;
      fv_q    <= 1'b0;
      flush_q <= 1'b0;
    end else if (load_now) begin
      pc_q    <= load_addr_d;
      pc4_q   <= load_addr_d + 32'd4;
      fv_q    <= 1'b0;
      flush_q <= 1'b1;
      state_q <= ST_FLUSH;
    end else if (park_now) begin
      // PC and fetch_valid stay frozen while the target waits out the stall.
      pend_q  <= redirect_target;
      flush_q <= 1'b0;
      state_q <= ST_HELD;
    end else if (state_q == ST_HELD) begin
      flush_q <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      state_q <= ST_RUN;
      if (!stall_in) begin
        pc_q  <= pc4_q;
        pc4_q <= pc4_q + 32'd4;
        fv_q  <= 1'b1;
      end else if (state_q == ST_FLUSH) begin
        // The post-flush fetch is real even if IF is stalled on it.
        fv_q <= 1'b1;
      end
    end
  end

  assign pc_out        = pc_q;
  assign pc_plus_4_out = pc4_q;
  assign fetch_valid   = fv_q;
  assign flush_if_id   = flush_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fv;
    logic        fl;
    logic        err;
    logic        rdy;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        redirect_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4_out;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        misalign_err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  pc_fetch_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .redirect_ready  (redirect_ready),
    .pc_out          (pc_out),
    .pc_plus_4_out   (pc_plus_4_out),
    .fetch_valid     (fetch_valid),
    .flush_if_id     (flush_if_id),
    .misalign_err    (misalign_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every negedge after a vector's edge, compare against the queued expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("pc_plus_4_out", pc_plus_4_out, e.pc4);
        chk("fetch_valid", {31'h0, fetch_valid}, {31'h0, e.fv});
        chk("flush_if_id", {31'h0, flush_if_id}, {31'h0, e.fl});
        chk("misalign_err", {31'h0, misalign_err}, {31'h0, e.err});
        chk("redirect_ready", {31'h0, redirect_ready}, {31'h0, e.rdy});
      end
    end
  end

  // Apply inputs for one cycle; expectation describes outputs after the sampling edge.
  // e_rdy reflects the post-edge state with the *next* vector's reset already driven.
  task automatic vec(input logic rst, input logic stl, input logic vld, input logic [31:0] tgt,
                     input logic [31:0] e_pc, input logic [31:0] e_pc4, input logic e_fv,
                     input logic e_fl, input logic e_err, input logic e_rdy);
    exp_t e;
    reset           = rst;
    stall_in        = stl;
    redirect_valid  = vld;
    redirect_target = tgt;
    @(posedge clock);
    e.pc = e_pc; e.pc4 = e_pc4; e.fv = e_fv; e.fl = e_fl; e.err = e_err; e.rdy = e_rdy;
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    logic [31:0] m_pc;
    logic        m_err;
    @(negedge clock);
    // 1. reset then free-run
    vec(1, 0, 0, 0, 32'h0, 32'h4, 0, 0, 0, 0);
    vec(1, 0, 0, 0, 32'h0, 32'h4, 0, 0, 0, 0);
    vec(1, 0, 0, 0, 32'h0, 32'h4, 0, 0, 0, 1);
    vec(0, 0, 0, 0, 32'h4, 32'h8, 1, 0, 0, 1);
    vec(0, 0, 0, 0, 32'h8, 32'hC, 1, 0, 0, 1);
    vec(0, 0, 0, 0, 32'hC, 32'h10, 1, 0, 0, 1);
    vec(0, 0, 0, 0, 32'h10, 32'h14, 1, 0, 0, 1);
    // 2. redirect at pc=0x10
    vec(0, 0, 1, 32'h400, 32'h400, 32'h404, 0, 1, 0, 1);
    vec(0, 0, 0, 0, 32'h404, 32'h408, 1, 0, 0, 1);
    // 3. redirect during stall, second redirect ignored while HELD
    vec(0, 1, 1, 32'h200, 32'h404, 32'h408, 1, 0, 0, 0);
    vec(0, 1, 1, 32'h600, 32'h404, 32'h408, 1, 0, 0, 0);
    vec(0, 1, 1, 32'h600, 32'h404, 32'h408, 1, 0, 0, 0);
    vec(0, 0, 1, 32'h600, 32'h200, 32'h204, 0, 1, 0, 1);
    vec(0, 0, 0, 0, 32'h204, 32'h208, 1, 0, 0, 1);
    // 4. back-to-back redirects: newest wins, flush re-pulses
    vec(0, 0, 1, 32'h100, 32'h100, 32'h104, 0, 1, 0, 1);
    vec(0, 0, 1, 32'h300, 32'h300, 32'h304, 0, 1, 0, 1);
    vec(0, 0, 0, 0, 32'h304, 32'h308, 1, 0, 0, 1);
    // FLUSH followed by stall: pc held, fetch_valid rises
    vec(0, 0, 1, 32'h500, 32'h500, 32'h504, 0, 1, 0, 1);
    vec(0, 1, 0, 0, 32'h500, 32'h504, 1, 0, 0, 1);
    vec(0, 1, 0, 0, 32'h500, 32'h504, 1, 0, 0, 1);
    vec(0, 0, 0, 0, 32'h504, 32'h508, 1, 0, 0, 1);
    // 5. wrap at top of address space
    vec(0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 1, 0, 1);
    vec(0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 1, 0, 0, 1);
    vec(0, 0, 0, 0, 32'h0, 32'h4, 1, 0, 0, 1);
    vec(0, 0, 0, 0, 32'h4, 32'h8, 1, 0, 0, 1);
    // 6. misaligned redirect (direct)
    m_pc  = TRAP ? 32'h80 : 32'h400;
    m_err = TRAP;
    vec(0, 0, 1, 32'h402, m_pc, m_pc + 32'd4, 0, 1, m_err, 1);
    vec(0, 0, 0, 0, m_pc + 32'd4, m_pc + 32'd8, 1, 0, m_err, 1);
    // misaligned redirect parked behind a stall
    vec(0, 1, 1, 32'h203, m_pc + 32'd4, m_pc + 32'd8, 1, 0, m_err, 0);
    m_pc = TRAP ? 32'h80 : 32'h200;
    vec(0, 0, 0, 0, m_pc, m_pc + 32'd4, 0, 1, m_err, 1);
    vec(0, 0, 0, 0, m_pc + 32'd4, m_pc + 32'd8, 1, 0, m_err, 1);
    // reset while HELD discards the pending target and clears the sticky error
    vec(0, 1, 1, 32'h700, m_pc + 32'd4, m_pc + 32'd8, 1, 0, m_err, 0);
    vec(1, 1, 0, 0, 32'h0, 32'h4, 0, 0, 0, 1);
    vec(0, 1, 0, 0, 32'h0, 32'h4, 0, 0, 0, 1);
    vec(0, 0, 0, 0, 32'h4, 32'h8, 1, 0, 0, 1);
    vec(0, 0, 0, 0, 32'h8, 32'hC, 1, 0, 0, 1);
    redirect_valid = 1'b0;
    stall_in       = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
